// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding and timing constants for the button debouncer
package btn_pkg;

  typedef enum logic [1:0] {
    S_LO     = 2'd0,
    S_CHK_HI = 2'd1,
    S_HI     = 2'd2,
    S_CHK_LO = 2'd3
  } btn_state_t;

  // 10 ms at 25 MHz
  localparam int DEB_CYCLES_DEF = 250000;
  // short window so simulation reaches acceptance in a handful of cycles
  localparam int DEB_CYCLES_SIM = 4;

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchroniser, debounce FSM, edge pulses, sticky flag
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic clr,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic latch
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             accept_hi;

  // Two-flop synchroniser; everything downstream only looks at sync2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The edge that accepts a new high level is also the edge that sets the flag
  always_comb begin
    accept_hi = (state == S_CHK_HI) && sync2 && (cnt == CNT_LAST);
  end

  // Debounce FSM: a differing sample starts a count, any agreeing sample aborts it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_LO;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        S_LO: begin
          if (sync2) begin
            cnt   <= CNT_ONE;
            state <= S_CHK_HI;
          end else begin
            cnt <= '0;
          end
        end
        S_CHK_HI: begin
          if (!sync2) begin
            cnt   <= '0;
            state <= S_LO;
          end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            state  <= S_HI;
            stable <= 1'b1;
            rise   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_HI: begin
          if (!sync2) begin
            cnt   <= CNT_ONE;
            state <= S_CHK_LO;
          end else begin
            cnt <= '0;
          end
        end
        S_CHK_LO: begin
          if (sync2) begin
            cnt   <= '0;
            state <= S_HI;
          end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            state  <= S_LO;
            stable <= 1'b0;
            fall   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_LO;
        end
      endcase
    end
  end

  // Sticky press flag; a press landing on the clear strobe wins so it is not lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      latch <= 1'b0;
    end else if (accept_hi) begin
      latch <= 1'b1;
    end else if (clr) begin
      latch <= 1'b0;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - N_BTN independent debounced button channels
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN      = 5,
  parameter int CNT_W      = 20,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] evt_clr,
  output logic [N_BTN-1:0] btn_stable,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic [N_BTN-1:0] evt_latch
);

  // One self-contained channel per button; they share nothing but clock and reset
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .CNT_W      (CNT_W),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw    (btn_raw[i]),
      .clr    (evt_clr[i]),
      .stable (btn_stable[i]),
      .rise   (btn_rise[i]),
      .fall   (btn_fall[i]),
      .latch  (evt_latch[i])
    );
  end

endmodule
